// File: rtl/sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_init_sequencer
// Description : Walks a register-init table and feeds writes, delays and
//               retries to an SCCB byte engine.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_init_sequencer #(
    parameter int          ROM_AW    = 8,
    parameter int          RA_BYTES  = 1,
    parameter int          MAX_RETRY = 3,
    parameter logic [23:0] DELAY_CYC = 24'd2_700_000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [8*(RA_BYTES+1)-1:0] rom_data,
    output logic [7:0]                data_out,
    output logic                      store_data,
    output logic                      send_data,
    input  logic                      engine_rdy,
    input  logic                      engine_err,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [7:0]                retry_cnt
);
    localparam int c_DW = 8 * (RA_BYTES + 1);

    typedef enum logic [3:0] {
        S_PWRUP = 4'd0, S_FETCH = 4'd1, S_CHECK = 4'd2, S_LOAD  = 4'd3,
        S_SEND  = 4'd4, S_WAIT  = 4'd5, S_DELAY = 4'd6, S_RETRY = 4'd7,
        S_DONE  = 4'd8, S_FAIL  = 4'd9
    } state_t;

    state_t              r_state, w_state;
    logic [ROM_AW-1:0]   r_rom_addr, w_rom_addr;
    logic [7:0]          r_data_out, w_data_out;
    logic                r_store, w_store, r_send, w_send;
    logic [23:0]         r_cnt, w_cnt;
    logic [1:0]          r_byte_idx, w_byte_idx;
    logic [7:0]          r_entry_retry, w_entry_retry;
    logic [7:0]          r_retry_cnt, w_retry_cnt;
    logic                r_wait_first, w_wait_first;
    logic                r_retry_armed, w_retry_armed;
    logic                r_busy, r_done, r_fail;

    logic [7:0] w_load_byte;
    logic       w_ra_ones, w_is_end, w_is_delay, w_cnt_last, w_last_byte;
    logic       w_addr_last, w_can_retry;

    // Register address goes out MSB first, the value byte last
    always_comb begin
        w_load_byte = rom_data[7:0];
        for (int i = 0; i < RA_BYTES; i++) begin
            if (r_byte_idx == 2'(i)) w_load_byte = rom_data[c_DW-1-8*i -: 8];
        end
    end

    assign w_ra_ones   = &rom_data[c_DW-1:8];
    assign w_is_end    = w_ra_ones && (rom_data[7:0] == 8'hFF);
    assign w_is_delay  = w_ra_ones && (rom_data[7:0] == 8'hF0);
    assign w_cnt_last  = (r_cnt >= DELAY_CYC - 24'd1);
    assign w_last_byte = (r_byte_idx == 2'(RA_BYTES));
    assign w_addr_last = &r_rom_addr;
    assign w_can_retry = (r_entry_retry < 8'(MAX_RETRY));

    always_comb begin
        w_state       = r_state;
        w_rom_addr    = r_rom_addr;
        w_data_out    = r_data_out;
        w_store       = 1'b0;
        w_send        = 1'b0;
        w_cnt         = r_cnt;
        w_byte_idx    = r_byte_idx;
        w_entry_retry = r_entry_retry;
        w_retry_cnt   = r_retry_cnt;
        w_wait_first  = 1'b0;
        w_retry_armed = r_retry_armed;
        case (r_state)
            S_PWRUP: begin
                if (!w_cnt_last) begin
                    w_cnt = r_cnt + 24'd1;
                end else if (engine_rdy) begin
                    w_state    = S_FETCH;
                    w_rom_addr = '0;
                end
            end
            S_FETCH: w_state = S_CHECK;
            S_CHECK: begin
                if (w_is_end) begin
                    w_state = S_DONE;
                end else if (w_is_delay) begin
                    w_state = S_DELAY;
                    w_cnt   = '0;
                end else begin
                    w_state    = S_LOAD;
                    w_byte_idx = '0;
                end
            end
            S_LOAD: begin
                w_data_out = w_load_byte;
                w_store    = 1'b1;
                if (w_last_byte) w_state = S_SEND;
                else             w_byte_idx = r_byte_idx + 2'd1;
            end
            S_SEND: begin
                w_send       = 1'b1;
                w_state      = S_WAIT;
                w_wait_first = 1'b1;
            end
            S_WAIT: begin
                // The first WAIT cycle overlaps the send strobe, so the engine status is stale
                if (!r_wait_first) begin
                    if (engine_err) begin
                        w_state       = S_RETRY;
                        w_retry_armed = 1'b0;
                    end else if (engine_rdy) begin
                        w_entry_retry = '0;
                        if (w_addr_last) begin
                            w_state = S_FAIL;
                        end else begin
                            w_rom_addr = r_rom_addr + ROM_AW'(1);
                            w_state    = S_FETCH;
                        end
                    end
                end
            end
            S_DELAY: begin
                if (!w_cnt_last) begin
                    w_cnt = r_cnt + 24'd1;
                end else if (w_addr_last) begin
                    w_state = S_FAIL;
                end else begin
                    w_rom_addr = r_rom_addr + ROM_AW'(1);
                    w_state    = S_FETCH;
                end
            end
            S_RETRY: begin
                if (!r_retry_armed) begin
                    if (w_can_retry) begin
                        w_entry_retry = r_entry_retry + 8'd1;
                        w_retry_cnt   = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;
                        w_retry_armed = 1'b1;
                    end else begin
                        w_state = S_FAIL;
                    end
                end else if (engine_rdy) begin
                    w_retry_armed = 1'b0;
                    w_state       = S_LOAD;
                    w_byte_idx    = '0;
                end
            end
            S_DONE, S_FAIL: begin
                if (start) begin
                    w_state       = S_FETCH;
                    w_rom_addr    = '0;
                    w_entry_retry = '0;
                    w_retry_cnt   = '0;
                    w_retry_armed = 1'b0;
                end
            end
            default: w_state = S_PWRUP;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_PWRUP;
            r_rom_addr    <= '0;
            r_data_out    <= '0;
            r_store       <= 1'b0;
            r_send        <= 1'b0;
            r_cnt         <= '0;
            r_byte_idx    <= '0;
            r_entry_retry <= '0;
            r_retry_cnt   <= '0;
            r_wait_first  <= 1'b0;
            r_retry_armed <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_rom_addr    <= w_rom_addr;
            r_data_out    <= w_data_out;
            r_store       <= w_store;
            r_send        <= w_send;
            r_cnt         <= w_cnt;
            r_byte_idx    <= w_byte_idx;
            r_entry_retry <= w_entry_retry;
            r_retry_cnt   <= w_retry_cnt;
            r_wait_first  <= w_wait_first;
            r_retry_armed <= w_retry_armed;
            r_busy        <= (w_state != S_DONE) && (w_state != S_FAIL);
            r_done        <= (w_state == S_DONE);
            r_fail        <= (w_state == S_FAIL);
        end
    end

    assign rom_addr   = r_rom_addr;
    assign data_out   = r_data_out;
    assign store_data = r_store;
    assign send_data  = r_send;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign retry_cnt  = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_init_sequencer
// Description : Scoreboard bench for sccb_init_sequencer (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_init_sequencer;

    logic             clk;
    logic [1:0]       rst_n   = 2'b00;
    logic [1:0]       start_v = 2'b00;
    logic [1:0]       rdy_v   = 2'b11;
    logic [1:0]       err_v   = 2'b00;
    logic [1:0]       store_v, send_v, busy_v, done_v, fail_v;
    logic [1:0][7:0]  dout_v, rcnt_v;
    logic [3:0]       addr0;
    logic [2:0]       addr1;
    logic [15:0]      rom0 [16];
    logic [23:0]      rom1 [8];
    logic [15:0]      rd0;
    logic [23:0]      rd1;

    logic [8:0] exp0[$], exp1[$];
    int         resp0[$], resp1[$];
    int         st_cyc1[$];
    int         send_cyc1 = -1;
    int         first_st0 = -1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    assign rd0 = rom0[addr0];
    assign rd1 = rom1[addr1];

    sccb_init_sequencer #(.ROM_AW(4), .RA_BYTES(1), .MAX_RETRY(2), .DELAY_CYC(24'd100)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n[0]), .start(start_v[0]),
        .rom_addr(addr0), .rom_data(rd0),
        .data_out(dout_v[0]), .store_data(store_v[0]), .send_data(send_v[0]),
        .engine_rdy(rdy_v[0]), .engine_err(err_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]), .retry_cnt(rcnt_v[0])
    );

    sccb_init_sequencer #(.ROM_AW(3), .RA_BYTES(2), .MAX_RETRY(1), .DELAY_CYC(24'd20)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n[1]), .start(start_v[1]),
        .rom_addr(addr1), .rom_data(rd1),
        .data_out(dout_v[1]), .store_data(store_v[1]), .send_data(send_v[1]),
        .engine_rdy(rdy_v[1]), .engine_err(err_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]), .retry_cnt(rcnt_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr0(input logic [7:0] a, input logic [7:0] v);
        exp0.push_back({1'b0, a});
        exp0.push_back({1'b0, v});
        exp0.push_back(9'h100);
    endtask

    task automatic push_wr1(input logic [15:0] a, input logic [7:0] v);
        exp1.push_back({1'b0, a[15:8]});
        exp1.push_back({1'b0, a[7:0]});
        exp1.push_back({1'b0, v});
        exp1.push_back(9'h100);
    endtask

    // Response codes: 0 ack, 1 error then idle, 2 error together with ready
    task automatic engine(input int k);
        int r;
        forever begin
            @(negedge clk);
            if (send_v[k]) begin
                r = 0;
                if (k == 0) begin
                    if (resp0.size() > 0) r = resp0.pop_front();
                end else if (resp1.size() > 0) begin
                    r = resp1.pop_front();
                end
                rdy_v[k] = 1'b0;
                err_v[k] = 1'b0;
                repeat (10) @(negedge clk);
                if (r == 0) begin
                    rdy_v[k] = 1'b1;
                end else begin
                    err_v[k] = 1'b1;
                    rdy_v[k] = (r == 2);
                    repeat (2) @(negedge clk);
                    err_v[k] = 1'b0;
                    rdy_v[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic monitor(input int k);
        logic [8:0] got, want;
        forever begin
            @(negedge clk);
            if (store_v[k] || send_v[k]) begin
                chk("strobe_overlap", 32'(store_v[k] & send_v[k]), 32'd0);
                got = send_v[k] ? 9'h100 : {1'b0, dout_v[k]};
                if (k == 0) want = (exp0.size() > 0) ? exp0.pop_front() : 9'h1FF;
                else        want = (exp1.size() > 0) ? exp1.pop_front() : 9'h1FF;
                chk((k == 0) ? "stream0" : "stream1", 32'(got), 32'(want));
                if (store_v[k] && k == 0 && first_st0 < 0) first_st0 = cyc;
                if (store_v[k] && k == 1) st_cyc1.push_back(cyc);
                if (send_v[k] && k == 1) send_cyc1 = cyc;
            end
        end
    endtask

    initial fork
        engine(0);
        engine(1);
        monitor(0);
        monitor(1);
    join

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_end(input int k, input int budget, input string tag);
        int n;
        n = 0;
        while (!(done_v[k] || fail_v[k]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) rom0[i] = 16'hFFFF;
        rom0[0] = 16'h1280;
        rom0[1] = 16'h1101;
    endtask

    initial begin
        int n, strobes, rel;
        for (int i = 0; i < 8; i++) rom1[i] = 24'hFFFFFF;
        load_basic();
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_busy", 32'(busy_v[0]), 32'd1);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_fail", 32'(fail_v[0]), 32'd0);
        chk("rst_retry", 32'(rcnt_v[0]), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_strobes", 32'({store_v[0], send_v[0]}), 32'd0);
        chk("rst_dout", 32'(dout_v[0]), 32'd0);

        // Basic two-write table
        push_wr0(8'h12, 8'h80);
        push_wr0(8'h11, 8'h01);
        rel = cyc;
        rst_n[0] = 1'b1;
        wait_end(0, 2000, "basic_timeout");
        chk("pwrup_wait", 32'((first_st0 - rel) >= 100), 32'd1);
        chk("basic_done", 32'(done_v[0]), 32'd1);
        chk("basic_busy", 32'(busy_v[0]), 32'd0);
        chk("basic_retry", 32'(rcnt_v[0]), 32'd0);
        chk("basic_addr", 32'(addr0), 32'd2);
        chk("basic_drain", 32'(exp0.size()), 32'd0);

        // Two errors on entry 1, then success
        resp0.push_back(0); resp0.push_back(1); resp0.push_back(1); resp0.push_back(0);
        push_wr0(8'h12, 8'h80);
        repeat (3) push_wr0(8'h11, 8'h01);
        pulse_start(0);
        chk("restart_addr", 32'(addr0), 32'd0);
        chk("restart_busy", 32'(busy_v[0]), 32'd1);
        wait_end(0, 2000, "retry_timeout");
        chk("retry_done", 32'(done_v[0]), 32'd1);
        chk("retry_cnt2", 32'(rcnt_v[0]), 32'd2);
        chk("retry_addr", 32'(addr0), 32'd2);
        chk("retry_drain", 32'(exp0.size()), 32'd0);

        // Delay entry, ignored start, simultaneous err+rdy
        rom0[1] = 16'hFFF0;
        rom0[2] = 16'h1101;
        resp0.push_back(0); resp0.push_back(2); resp0.push_back(0);
        push_wr0(8'h12, 8'h80);
        push_wr0(8'h11, 8'h01);
        push_wr0(8'h11, 8'h01);
        pulse_start(0);
        n = 0;
        while (addr0 != 4'd1 && n < 500) begin @(negedge clk); n++; end
        chk("delay_reach", 32'(n < 500), 32'd1);
        n = 0;
        strobes = 0;
        while (addr0 == 4'd1 && n < 500) begin
            if (store_v[0] || send_v[0]) strobes++;
            start_v[0] = (n == 50);
            @(negedge clk);
            n++;
        end
        start_v[0] = 1'b0;
        chk("delay_len", 32'(n >= 100 && n <= 110), 32'd1);
        chk("delay_quiet", 32'(strobes), 32'd0);
        wait_end(0, 2000, "delay_timeout");
        chk("delay_done", 32'(done_v[0]), 32'd1);
        chk("errrdy_retry", 32'(rcnt_v[0]), 32'd1);
        chk("delay_drain", 32'(exp0.size()), 32'd0);

        // Persistent error -> FAIL, then restart
        load_basic();
        resp0.push_back(1); resp0.push_back(1); resp0.push_back(1);
        repeat (3) push_wr0(8'h12, 8'h80);
        pulse_start(0);
        wait_end(0, 2000, "perr_timeout");
        chk("perr_fail", 32'(fail_v[0]), 32'd1);
        chk("perr_done", 32'(done_v[0]), 32'd0);
        chk("perr_busy", 32'(busy_v[0]), 32'd0);
        chk("perr_retry", 32'(rcnt_v[0]), 32'd2);
        chk("perr_drain", 32'(exp0.size()), 32'd0);
        push_wr0(8'h12, 8'h80);
        push_wr0(8'h11, 8'h01);
        pulse_start(0);
        chk("fail_restart_retry", 32'(rcnt_v[0]), 32'd0);
        chk("fail_restart_busy", 32'(busy_v[0]), 32'd1);
        wait_end(0, 2000, "fail_restart_timeout");
        chk("fail_restart_done", 32'(done_v[0]), 32'd1);

        // Table without END: last entry completes then FAIL, no wrap
        for (int i = 0; i < 16; i++) begin
            rom0[i] = {8'h01, 8'(i)};
            push_wr0(8'h01, 8'(i));
        end
        pulse_start(0);
        wait_end(0, 4000, "wrap_timeout");
        chk("wrap_fail", 32'(fail_v[0]), 32'd1);
        chk("wrap_addr", 32'(addr0), 32'd15);
        chk("wrap_drain", 32'(exp0.size()), 32'd0);

        // Reset during LOAD of entry 3
        for (int i = 0; i < 16; i++) rom0[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            rom0[i] = {8'(8'h20 + i), 8'(i)};
            push_wr0(8'(8'h20 + i), 8'(i));
        end
        pulse_start(0);
        n = 0;
        while (!(addr0 == 4'd3 && store_v[0]) && n < 1000) begin @(negedge clk); n++; end
        chk("load3_reach", 32'(n < 1000), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("midrst_store", 32'(store_v[0]), 32'd0);
        chk("midrst_addr", 32'(addr0), 32'd0);
        chk("midrst_dout", 32'(dout_v[0]), 32'd0);
        chk("midrst_busy", 32'(busy_v[0]), 32'd1);
        exp0.delete();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) push_wr0(8'(8'h20 + i), 8'(i));
        first_st0 = -1;
        rel = cyc;
        rst_n[0] = 1'b1;
        wait_end(0, 2000, "midrst_timeout");
        chk("midrst_pwrup", 32'((first_st0 - rel) >= 100), 32'd1);
        chk("midrst_done", 32'(done_v[0]), 32'd1);
        chk("midrst_end_addr", 32'(addr0), 32'd4);
        chk("midrst_drain", 32'(exp0.size()), 32'd0);

        // Two-byte register address instance
        rom1[0] = 24'h300A56;
        push_wr1(16'h300A, 8'h56);
        rst_n[1] = 1'b1;
        wait_end(1, 1000, "ra2_timeout");
        chk("ra2_done", 32'(done_v[1]), 32'd1);
        chk("ra2_consec", 32'(st_cyc1.size() == 3 && st_cyc1[1] == st_cyc1[0] + 1
                              && st_cyc1[2] == st_cyc1[1] + 1), 32'd1);
        chk("ra2_send_after", 32'(st_cyc1.size() == 3 && send_cyc1 > st_cyc1[2]), 32'd1);
        chk("ra2_drain", 32'(exp1.size()), 32'd0);

        resp1.push_back(1); resp1.push_back(1);
        repeat (2) push_wr1(16'h300A, 8'h56);
        pulse_start(1);
        wait_end(1, 1000, "ra2_fail_timeout");
        chk("ra2_fail", 32'(fail_v[1]), 32'd1);
        chk("ra2_fail_busy", 32'(busy_v[1]), 32'd0);
        chk("ra2_fail_retry", 32'(rcnt_v[1]), 32'd1);
        chk("ra2_fail_drain", 32'(exp1.size()), 32'd0);
        push_wr1(16'h300A, 8'h56);
        pulse_start(1);
        chk("ra2_restart_addr", 32'(addr1), 32'd0);
        chk("ra2_restart_retry", 32'(rcnt_v[1]), 32'd0);
        wait_end(1, 1000, "ra2_restart_timeout");
        chk("ra2_restart_done", 32'(done_v[1]), 32'd1);
        chk("ra2_restart_drain", 32'(exp1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
